// File: rtl/lcd_sequencer.sv
// lcd_sequencer: turns high-level LCD commands into ordered driver strobes.
//
// A command (INIT, CLEAR, GOTO, PRINT) is accepted in IDLE and expanded into
// a list of steps. Each step raises one driver strobe, waits for lcd_busy to
// rise (ack), then waits for it to fall (done). Both waits are bounded by
// TIMEOUT cycles. PRINT consumes characters from an internal FIFO that is
// filled independently through wr_en/wr_data.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/op/arg         command request; op 0=INIT 1=CLEAR 2=GOTO 3=PRINT
//   cmd_ready                high while idle
//   done, err                one-cycle completion pulse; err qualifies done
//   wr_en, wr_data           character push into the FIFO
//   fifo_full, fifo_count    FIFO status
//   ovf                      pulse when a push is dropped on a full FIFO
//   lcd_en .. lcd_w_char     driver strobes, at most one high at a time
//   lcd_cursor_pos           operand for the cursor strobe
//   lcd_ascii_char           operand for the w_char strobe
//   lcd_busy                 driver busy flag
module lcd_sequencer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  input  logic [1:0]                  cmd_op,
  input  logic [7:0]                  cmd_arg,
  output logic                        cmd_ready,
  output logic                        done,
  output logic                        err,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        ovf,
  output logic                        lcd_en,
  output logic                        lcd_set,
  output logic                        lcd_clear,
  output logic                        lcd_on,
  output logic                        lcd_cursor,
  output logic                        lcd_w_char,
  output logic [7:0]                  lcd_cursor_pos,
  output logic [7:0]                  lcd_ascii_char,
  input  logic                        lcd_busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  // Strobe vector bit positions; INIT steps 0..3 map directly onto en/set/clear/on.
  localparam int unsigned StbEn     = 0;
  localparam int unsigned StbSet    = 1;
  localparam int unsigned StbClear  = 2;
  localparam int unsigned StbOn     = 3;
  localparam int unsigned StbCursor = 4;
  localparam int unsigned StbChar   = 5;

  typedef enum logic [2:0] {
    StIdle, StIssue, StWaitAck, StWaitDone, StNext, StFinish
  } state_e;

  typedef enum logic [1:0] {
    OpInit  = 2'd0,
    OpClear = 2'd1,
    OpGoto  = 2'd2,
    OpPrint = 2'd3
  } op_e;

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic [7:0]  arg_q, arg_d;
  logic [7:0]  rem_q, rem_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] timer_q, timer_d;
  logic        err_q, err_d;
  logic [5:0]  stb_q, stb_d;
  logic [7:0]  cursor_pos_q, cursor_pos_d;
  logic [7:0]  ascii_q, ascii_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic full;
  logic push;
  logic pop;
  logic print_reject;
  logic timer_expired;
  logic [7:0] fifo_head;

  assign full          = (count_q == DepthCnt);
  assign fifo_head     = mem_q[rd_ptr_q];
  assign timer_expired = (timer_q == TimeoutLast);

  // PRINT is checked against the occupancy seen at acceptance.
  assign print_reject = (op_e'(cmd_op) == OpPrint) &&
                        ((cmd_arg == 8'd0) || (32'(cmd_arg) > 32'(count_q)));

  // The head is popped in the same cycle its w_char strobe is issued.
  assign pop  = (state_q == StIssue) && (op_q == OpPrint) && (count_q != '0);
  // A pop frees a slot this cycle, so a push into a full FIFO still lands.
  assign push = wr_en && (!full || pop);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = print_reject ? StFinish : StIssue;
        end
      end
      StIssue: state_d = StWaitAck;
      StWaitAck: begin
        if (lcd_busy) begin
          state_d = StWaitDone;
        end else if (timer_expired) begin
          state_d = StFinish;
        end
      end
      StWaitDone: begin
        if (!lcd_busy) begin
          state_d = StNext;
        end else if (timer_expired) begin
          state_d = StFinish;
        end
      end
      StNext:   state_d = (rem_q == 8'd1) ? StFinish : StIssue;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Step datapath: command capture, step counting, timer, strobes, operands
  // ---------------------------------------------------------------------------
  always_comb begin
    op_d         = op_q;
    arg_d        = arg_q;
    rem_d        = rem_q;
    idx_d        = idx_q;
    err_d        = err_q;
    cursor_pos_d = cursor_pos_q;
    ascii_d      = ascii_q;
    // Strobes and timer fall to zero unless a state explicitly keeps them.
    stb_d        = '0;
    timer_d      = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d  = op_e'(cmd_op);
          arg_d = cmd_arg;
          idx_d = '0;
          err_d = print_reject;
          unique case (op_e'(cmd_op))
            OpInit:  rem_d = 8'd4;
            OpPrint: rem_d = cmd_arg;
            default: rem_d = 8'd1;
          endcase
        end
      end
      StIssue: begin
        unique case (op_q)
          OpInit:  stb_d[{1'b0, idx_q}] = 1'b1;
          OpClear: stb_d[StbClear]      = 1'b1;
          OpGoto: begin
            stb_d[StbCursor] = 1'b1;
            cursor_pos_d     = arg_q;
          end
          OpPrint: begin
            stb_d[StbChar] = 1'b1;
            ascii_d        = fifo_head;
          end
          default: ;
        endcase
      end
      StWaitAck: begin
        if (!lcd_busy) begin
          if (timer_expired) begin
            err_d = 1'b1;
          end else begin
            stb_d   = stb_q;
            timer_d = timer_q + 16'd1;
          end
        end
      end
      StWaitDone: begin
        if (lcd_busy) begin
          if (timer_expired) begin
            err_d = 1'b1;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
      end
      StNext: begin
        rem_d = rem_q - 8'd1;
        idx_d = idx_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= OpInit;
      arg_q        <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      stb_q        <= '0;
      cursor_pos_q <= '0;
      ascii_q      <= '0;
    end else begin
      op_q         <= op_d;
      arg_q        <= arg_d;
      rem_q        <= rem_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      stb_q        <= stb_d;
      cursor_pos_q <= cursor_pos_d;
      ascii_q      <= ascii_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Character FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM / datapath outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready      = (state_q == StIdle);
    done           = (state_q == StFinish);
    err            = (state_q == StFinish) && err_q;
    lcd_en         = stb_q[StbEn];
    lcd_set        = stb_q[StbSet];
    lcd_clear      = stb_q[StbClear];
    lcd_on         = stb_q[StbOn];
    lcd_cursor     = stb_q[StbCursor];
    lcd_w_char     = stb_q[StbChar];
    lcd_cursor_pos = cursor_pos_q;
    lcd_ascii_char = ascii_q;
    fifo_full      = full;
    fifo_count     = count_q;
    ovf            = wr_en && full && !pop;
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: directed scenarios plus randomized commands,
// checked against a queue-based model of the FIFO and the step lists.
module tb_lcd_sequencer;

  localparam int Depth = 16;

  typedef struct packed {
    logic [2:0] id;    // 0 en, 1 set, 2 clear, 3 on, 4 cursor, 5 w_char
    logic [7:0] opnd;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       cmd_ready, done, err;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       ovf;
  logic       lcd_en, lcd_set, lcd_clear, lcd_on, lcd_cursor, lcd_w_char;
  logic [7:0] lcd_cursor_pos, lcd_ascii_char;
  logic       lcd_busy = 1'b0;

  logic [5:0] stb_vec;
  logic [5:0] prev_stb = '0;
  assign stb_vec = {lcd_w_char, lcd_cursor, lcd_on, lcd_clear, lcd_set, lcd_en};

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int cursor_cycles = 0;
  int onehot_viol = 0;
  int bmode = 0;      // 0 responsive, 1 busy stuck low, 2 busy latched high
  int ack_max = 0;
  int len_fix = 3;
  int busy_left = 0;
  int ack_wait = 0;

  ev_t        ev_q[$];
  ev_t        exp_q[$];
  logic [7:0] model_q[$];

  lcd_sequencer #(
    .FIFO_DEPTH(Depth),
    .TIMEOUT   (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_arg       (cmd_arg),
    .cmd_ready     (cmd_ready),
    .done          (done),
    .err           (err),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .fifo_full     (fifo_full),
    .fifo_count    (fifo_count),
    .ovf           (ovf),
    .lcd_en        (lcd_en),
    .lcd_set       (lcd_set),
    .lcd_clear     (lcd_clear),
    .lcd_on        (lcd_on),
    .lcd_cursor    (lcd_cursor),
    .lcd_w_char    (lcd_w_char),
    .lcd_cursor_pos(lcd_cursor_pos),
    .lcd_ascii_char(lcd_ascii_char),
    .lcd_busy      (lcd_busy)
  );

  always #5 clk = ~clk;

  // Monitor: log strobe rising edges with their operand, count done pulses.
  always @(negedge clk) begin
    ev_t v;
    if (!rst) begin
      if ($countones(stb_vec) > 1) onehot_viol++;
      if (done) done_cnt++;
      if (lcd_cursor) cursor_cycles++;
      for (int i = 0; i < 6; i++) begin
        if (stb_vec[i] && !prev_stb[i]) begin
          v.id   = 3'(i);
          v.opnd = (i == 4) ? lcd_cursor_pos : ((i == 5) ? lcd_ascii_char : 8'h00);
          ev_q.push_back(v);
        end
      end
    end
    prev_stb = stb_vec;
  end

  // Driver model for lcd_busy.
  always @(negedge clk) begin
    if (bmode == 1) begin
      lcd_busy  = 1'b0;
      busy_left = 0;
    end else if (bmode == 2) begin
      if (stb_vec != '0) lcd_busy = 1'b1;
    end else if (busy_left != 0) begin
      busy_left--;
      lcd_busy = (busy_left != 0);
    end else begin
      lcd_busy = 1'b0;
      if (stb_vec != '0) begin
        if (ack_wait != 0) begin
          ack_wait--;
        end else begin
          lcd_busy  = 1'b1;
          busy_left = (len_fix != 0) ? len_fix : int'($urandom_range(1, 5));
          ack_wait  = int'($urandom_range(0, ack_max));
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected strobe list and error flag for one command.
  task automatic model_cmd(input logic [1:0] op, input logic [7:0] arg, output logic e);
    ev_t v;
    exp_q.delete();
    e = 1'b0;
    v.opnd = 8'h00;
    case (op)
      2'd0: for (int i = 0; i < 4; i++) begin v.id = 3'(i); exp_q.push_back(v); end
      2'd1: begin v.id = 3'd2; exp_q.push_back(v); end
      2'd2: begin v.id = 3'd4; v.opnd = arg; exp_q.push_back(v); end
      default: begin
        if (arg == 8'd0 || int'(arg) > model_q.size()) begin
          e = 1'b1;
        end else begin
          for (int i = 0; i < int'(arg); i++) begin
            v.id = 3'd5;
            v.opnd = model_q.pop_front();
            exp_q.push_back(v);
          end
        end
      end
    endcase
  endtask

  task automatic push_char(input logic [7:0] c);
    bit full_exp;
    full_exp = (model_q.size() == Depth);
    wr_en = 1'b1;
    wr_data = c;
    #1;
    check("push_ovf", 32'(ovf), 32'(full_exp));
    check("push_full", 32'(fifo_full), 32'(full_exp));
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (!full_exp) model_q.push_back(c);
    check("push_count", 32'(fifo_count), 32'(model_q.size()));
  endtask

  // spam: hold cmd_valid during the command; to: a timeout is expected;
  // pin: push pc in the cycle the first character is popped.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg, input bit spam,
                         input bit to, input bit pin, input logic [7:0] pc,
                         input string tag, output int lat);
    logic e;
    int base_ev;
    int base_done;
    int n;
    base_ev = ev_q.size();
    base_done = done_cnt;
    model_cmd(op, arg, e);
    e = e | to;
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    @(posedge clk);
    #1;
    if (spam) cmd_op = 2'd1;
    else cmd_valid = 1'b0;
    if (pin) begin
      wr_en = 1'b1;
      wr_data = pc;
      model_q.push_back(pc);
      #1;
      check({tag, "_ovf_on_pop"}, 32'(ovf), 32'd0);
      check({tag, "_full_on_pop"}, 32'(fifo_full), 32'd1);
    end
    n = 0;
    while (!done && n < 300) begin
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      n++;
      if (pin && n == 1) check({tag, "_count_pushpop"}, 32'(fifo_count), 32'(model_q.size()));
    end
    cmd_valid = 1'b0;
    lat = n;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(e));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(cmd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_nev"}, 32'(ev_q.size() - base_ev), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base_ev + i < ev_q.size(); i++) begin
      check({tag, "_ev"}, 32'(ev_q[base_ev + i]), 32'(exp_q[i]));
    end
    check({tag, "_ndone"}, 32'(done_cnt - base_done), 32'd1);
    check({tag, "_count"}, 32'(fifo_count), 32'(model_q.size()));
  endtask

  initial begin
    int lat;
    int base;
    logic [1:0] op;
    logic [7:0] arg;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_arg = 8'd0;
    wr_en = 1'b0;
    wr_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_strobes", 32'(stb_vec), 32'd0);
    check("rst_done_err_ovf", 32'({done, err, ovf}), 32'd0);
    check("rst_operands", 32'({lcd_cursor_pos, lcd_ascii_char}), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // INIT with a 3-cycle busy per strobe.
    run_cmd(2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, "init", lat);

    // Push "HI" and print it.
    push_char(8'h48);
    push_char(8'h49);
    check("hi_count", 32'(fifo_count), 32'd2);
    run_cmd(2'd3, 8'd2, 1'b0, 1'b0, 1'b0, 8'd0, "print_hi", lat);

    // Over-long PRINT is rejected on the cycle after acceptance.
    push_char(8'h41);
    push_char(8'h42);
    run_cmd(2'd3, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, "print_long", lat);
    check("print_long_lat", 32'(lat), 32'd0);
    run_cmd(2'd3, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, "print_zero", lat);

    // GOTO with busy stuck low times out in the ack wait; cmd_valid held throughout.
    bmode = 1;
    base = cursor_cycles;
    run_cmd(2'd2, 8'h40, 1'b1, 1'b1, 1'b0, 8'd0, "goto_to", lat);
    check("goto_to_cycles", 32'(cursor_cycles - base), 32'd10);
    check("goto_pos_hold", 32'(lcd_cursor_pos), 32'h40);

    // Busy never falls: timeout in the done wait.
    bmode = 2;
    run_cmd(2'd1, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, "clear_to", lat);
    bmode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Randomized commands with random driver latency.
    len_fix = 0;
    ack_max = 3;
    for (int k = 0; k < 25; k++) begin
      int np;
      np = int'($urandom_range(0, 4));
      for (int j = 0; j < np; j++) push_char(8'($urandom_range(32, 126)));
      op = 2'($urandom_range(0, 3));
      if (op == 2'd3) arg = 8'($urandom_range(0, model_q.size() + 1));
      else arg = 8'($urandom_range(0, 255));
      run_cmd(op, arg, 1'b0, 1'b0, 1'b0, 8'd0, "rand", lat);
    end

    // Fill, overflow, then push while popping at full.
    while (model_q.size() < Depth) push_char(8'($urandom_range(32, 126)));
    check("fill_full", 32'(fifo_full), 32'd1);
    push_char(8'h5a);
    check("ovf_count", 32'(fifo_count), 32'd16);
    run_cmd(2'd3, 8'd1, 1'b0, 1'b0, 1'b1, 8'h7e, "popush", lat);

    // Reset in the done wait of a PRINT.
    bmode = 2;
    base = done_cnt;
    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    cmd_arg = 8'd2;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_strobes", 32'(stb_vec), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ascii", 32'(lcd_ascii_char), 32'd0);
    model_q.delete();
    bmode = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_nodone", 32'(done_cnt - base), 32'd0);
    push_char(8'h31);
    run_cmd(2'd3, 8'd1, 1'b0, 1'b0, 1'b0, 8'd0, "after_rst", lat);

    check("one_strobe", 32'(onehot_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, the character FIFO depth (power of two).
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, the maximum cycles allowed in each busy-wait phase (16-bit counter).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port cmd_valid, input, 1, command request.
REQ-006 The block SHALL have port cmd_op, input, 2, the opcode: 0=INIT, 1=CLEAR, 2=GOTO, 3=PRINT.
REQ-007 The block SHALL have port cmd_arg, input, 8, the cursor position (GOTO) or character count N (PRINT).
REQ-008 The block SHALL have port cmd_ready, output, 1, high only in IDLE.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse at command completion.
REQ-010 The block SHALL have port err, output, 1, valid only with done; 1 = rejected or timed out.
REQ-011 The block SHALL have port wr_en, input, 1, the character push strobe.
REQ-012 The block SHALL have port wr_data, input, 8, the ASCII character to push.
REQ-013 The block SHALL have port fifo_full, output, 1, FIFO full flag.
REQ-014 The block SHALL have port fifo_count, output, log2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-015 The block SHALL have port ovf, output, 1, a one-cycle pulse when a push is dropped.
REQ-016 The block SHALL have ports lcd_en, lcd_set, lcd_clear, lcd_on, lcd_cursor and lcd_w_char, each an output of width 1, the driver command strobes.
REQ-017 The block SHALL have ports lcd_cursor_pos and lcd_ascii_char, each an output of width 8, the driver operands.
REQ-018 The block SHALL have port lcd_busy, input, 1, the driver busy flag.

Function
REQ-019 States SHALL be IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT and FINISH.
REQ-020 A command SHALL be accepted on the cycle T where cmd_valid&&cmd_ready; the state becomes ISSUE at T+1.
REQ-021 Step lists SHALL be:
  - INIT: en, set, clear, on.
  - CLEAR: clear.
  - GOTO: cursor with lcd_cursor_pos=cmd_arg.
  - PRINT: N x w_char, each with lcd_ascii_char = the FIFO head popped in ISSUE.
REQ-022 PRINT with N==0 or N>fifo_count at acceptance SHALL go directly to FINISH with err=1, with no strobe and no pop.
REQ-023 ISSUE SHALL assert exactly one strobe with its operand stable, then go to WAIT_ACK.
REQ-024 The strobe SHALL stay high in WAIT_ACK until lcd_busy==1, then drop, with the next state WAIT_DONE.
REQ-025 WAIT_DONE SHALL wait for lcd_busy==0, then go to NEXT.
REQ-026 NEXT SHALL go to ISSUE if steps remain, else to FINISH.
REQ-027 The timeout counter SHALL clear on entry to WAIT_ACK and WAIT_DONE; reaching TIMEOUT in either state SHALL drop all strobes, abandon the remaining steps and go to FINISH with err=1.
REQ-028 FINISH SHALL pulse done for one cycle (err=0 unless set by REQ-022 or REQ-027) and then return to IDLE.
REQ-029 Operand outputs SHALL hold their last values between steps.
REQ-030 At most one strobe SHALL be high at any cycle.
REQ-031 FIFO push: wr_en && !full writes wr_data; wr_en && full drops the push and pulses ovf.
REQ-032 A simultaneous push and pop SHALL both succeed, including when the FIFO is full, leaving the count unchanged.
REQ-033 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 cmd_valid outside IDLE SHALL be ignored and not queued.

Reset
REQ-035 rst=1 SHALL immediately force:
  - State to IDLE.
  - All strobes, done, err and ovf to 0.
  - Operands to 0x00.
  - The FIFO to empty (count 0), and the timeout counter to 0.
REQ-036 A reset mid-operation SHALL abort the operation with no done pulse.
REQ-037 cmd_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-038 INIT with a driver model asserting busy for 3 cycles per strobe -> strobes en, set, clear, on occur in that order, each dropped on busy; done=1, err=0.
REQ-039 Push "HI", then PRINT N=2 -> two w_char strobes with lcd_ascii_char 0x48 then 0x49; fifo_count goes 2->0; done=1, err=0.
REQ-040 PRINT N=3 with fifo_count=2 -> no strobe, done=1, err=1 on cycle T+1, fifo_count stays 2.
REQ-041 GOTO 0x40 with lcd_busy stuck at 0, TIMEOUT=10 -> lcd_cursor high for 10 cycles then low; done=1, err=1.
REQ-042 Fill 16 chars, push a 17th -> ovf pulse, count=16; during a PRINT pop, a push on the same cycle is accepted and count stays 16.
REQ-043 rst asserted in WAIT_DONE of a PRINT -> strobes 0, fifo_count=0 and no done pulse, without waiting for a clock edge.
